// File: rtl/seq_control_pkg.sv
// Shared definitions for the microprogram sequencer controller: microword
// layout, op codes, source-select encodings and the condition test.
package seq_control_pkg;

    localparam int ADDR_W  = 12;
    localparam int UWORD_W = 24;
    localparam int COND_W  = 8;
    localparam int CTL_W   = 4;

    localparam int OP_HI    = 23;
    localparam int OP_LO    = 20;
    localparam int CSEL_HI  = 19;
    localparam int CSEL_LO  = 17;
    localparam int CPOL_BIT = 16;
    localparam int CTL_HI   = 15;
    localparam int CTL_LO   = 12;
    localparam int BR_HI    = 11;
    localparam int BR_LO    = 0;

    localparam logic [2:0] STK_MAX = 3'd4;

    typedef enum logic [3:0] {
        OP_JZ   = 4'h0,
        OP_CONT = 4'h1,
        OP_JMP  = 4'h2,
        OP_CJMP = 4'h3,
        OP_JSR  = 4'h4,
        OP_CJSR = 4'h5,
        OP_RTS  = 4'h6,
        OP_CRTS = 4'h7,
        OP_LDCT = 4'h8,
        OP_RPCT = 4'h9,
        OP_LDAR = 4'hA,
        OP_JAR  = 4'hB,
        OP_WAIT = 4'hC,
        OP_HOLD = 4'hD,
        OP_RSVE = 4'hE,
        OP_RSVF = 4'hF
    } op_e;

    // Slice source select {s1,s0}.
    typedef enum logic [1:0] {
        SRC_PC  = 2'b00,
        SRC_AR  = 2'b01,
        SRC_STK = 2'b10,
        SRC_D   = 2'b11
    } src_e;

    function automatic logic cond_test(input logic [COND_W-1:0] flags,
                                       input logic [2:0]        sel,
                                       input logic              pol);
        return flags[sel] ^ pol;
    endfunction

endpackage

// File: rtl/seq_control_loop_counter.sv
// Loop counter: parallel load, saturating decrement at zero, zero detect.
module loop_counter
    import seq_control_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_dec,
    input  logic [ADDR_W-1:0] i_din,
    output logic              o_zero
);

    logic [ADDR_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_din;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/seq_control.sv
// Microprogram sequencer controller: pipelines the microword, decodes it into
// slice controls, and tracks loop count and stack depth with sticky errors.
module seq_control
    import seq_control_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic [UWORD_W-1:0] uword,
    input  logic [COND_W-1:0]  cond_in,
    input  logic               ext_ready,
    output logic               s0,
    output logic               s1,
    output logic               fe_n,
    output logic               pup,
    output logic               zero_n,
    output logic               cin,
    output logic               re_n,
    output logic [ADDR_W-1:0]  din,
    output logic [ADDR_W-1:0]  rin,
    output logic [CTL_W-1:0]   ctl_out,
    output logic               stk_ovf,
    output logic               stk_unf
);

    logic [UWORD_W-1:0] r_pipe;
    logic [2:0]         r_depth;
    logic               r_ovf;
    logic               r_unf;

    op_e               w_op;
    logic              w_test;
    logic [ADDR_W-1:0] w_branch;
    src_e              w_src;
    logic              w_cin;
    logic              w_fe_n;
    logic              w_pup;
    logic              w_zero_n;
    logic              w_re_n;
    logic              w_push;
    logic              w_pop;
    logic              w_ld;
    logic              w_dec;
    logic              w_cnt_zero;

    // A cleared pipeline decodes as JZ, so reset drives the address to 0 at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= uword;
        end
    end

    assign w_op     = op_e'(r_pipe[OP_HI:OP_LO]);
    assign w_branch = r_pipe[BR_HI:BR_LO];
    assign w_test   = cond_test(cond_in, r_pipe[CSEL_HI:CSEL_LO], r_pipe[CPOL_BIT]);

    always_comb begin
        w_src    = SRC_PC;
        w_cin    = 1'b1;
        w_fe_n   = 1'b1;
        w_pup    = 1'b0;
        w_zero_n = 1'b1;
        w_re_n   = 1'b1;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        w_ld     = 1'b0;
        w_dec    = 1'b0;
        case (w_op)
            OP_JZ:   w_zero_n = 1'b0;
            OP_JMP:  w_src = SRC_D;
            OP_CJMP: if (w_test) w_src = SRC_D;
            OP_JSR: begin
                w_src  = SRC_D;
                w_fe_n = 1'b0;
                w_pup  = 1'b1;
                w_push = 1'b1;
            end
            OP_CJSR: if (w_test) begin
                w_src  = SRC_D;
                w_fe_n = 1'b0;
                w_pup  = 1'b1;
                w_push = 1'b1;
            end
            OP_RTS: begin
                w_src  = SRC_STK;
                w_fe_n = 1'b0;
                w_pop  = 1'b1;
            end
            OP_CRTS: if (w_test) begin
                w_src  = SRC_STK;
                w_fe_n = 1'b0;
                w_pop  = 1'b1;
            end
            OP_LDCT: w_ld = 1'b1;
            OP_RPCT: if (!w_cnt_zero) begin
                w_src = SRC_D;
                w_dec = 1'b1;
            end
            OP_LDAR: w_re_n = 1'b0;
            OP_JAR:  w_src = SRC_AR;
            OP_WAIT: w_cin = ext_ready;
            OP_HOLD: w_cin = 1'b0;
            default: w_src = SRC_PC;
        endcase
    end

    loop_counter u_loop_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .i_load  (w_ld),
        .i_dec   (w_dec),
        .i_din   (w_branch),
        .o_zero  (w_cnt_zero)
    );

    // Depth saturates at both ends; the slice stack is still strobed on error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (w_push) begin
            if (r_depth == STK_MAX) begin
                r_ovf <= 1'b1;
            end else begin
                r_depth <= r_depth + 3'd1;
            end
        end else if (w_pop) begin
            if (r_depth == 3'd0) begin
                r_unf <= 1'b1;
            end else begin
                r_depth <= r_depth - 3'd1;
            end
        end
    end

    assign s1      = w_src[1];
    assign s0      = w_src[0];
    assign fe_n    = w_fe_n;
    assign pup     = w_pup;
    assign zero_n  = w_zero_n;
    assign cin     = w_cin;
    assign re_n    = w_re_n;
    assign din     = w_branch;
    assign rin     = w_branch;
    assign ctl_out = r_pipe[CTL_HI:CTL_LO];
    assign stk_ovf = r_ovf;
    assign stk_unf = r_unf;

endmodule

// File: tb/tb_seq_control.sv
// Directed bench for seq_control with a minimal PC/Y model of the slices.
module tb_seq_control;
    import seq_control_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [23:0] uword;
    logic [7:0]  cond_in;
    logic        ext_ready;
    logic        s0, s1, fe_n, pup, zero_n, cin, re_n;
    logic [11:0] din, rin;
    logic [3:0]  ctl_out;
    logic        stk_ovf, stk_unf;

    int nvec  = 0;
    int nfail = 0;

    logic [11:0] tb_pc;
    logic [11:0] tb_y;

    seq_control dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .uword     (uword),
        .cond_in   (cond_in),
        .ext_ready (ext_ready),
        .s0        (s0),
        .s1        (s1),
        .fe_n      (fe_n),
        .pup       (pup),
        .zero_n    (zero_n),
        .cin       (cin),
        .re_n      (re_n),
        .din       (din),
        .rin       (rin),
        .ctl_out   (ctl_out),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slice address model: only the PC and direct-input paths are needed here.
    always_comb begin
        tb_y = 12'h000;
        if (zero_n) begin
            if ({s1, s0} == 2'b11) tb_y = din;
            else if ({s1, s0} == 2'b00) tb_y = tb_pc;
        end
    end

    always @(posedge clock) tb_pc <= tb_y + {11'd0, cin};

    function automatic logic [23:0] mk(input logic [3:0] op, input logic [2:0] sel,
                                       input logic pol, input logic [3:0] ctl,
                                       input logic [11:0] br);
        return {op, sel, pol, ctl, br};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // {s1,s0,cin,fe_n,pup,re_n,zero_n}
    function automatic logic [31:0] ctlv();
        return {25'd0, s1, s0, cin, fe_n, pup, re_n, zero_n};
    endfunction

    logic [3:0] tab_op  [12];
    logic [6:0] tab_exp [12];

    initial begin
        tab_op[0]  = 4'h0; tab_exp[0]  = 7'b00_1_1_0_1_0;
        tab_op[1]  = 4'h1; tab_exp[1]  = 7'b00_1_1_0_1_1;
        tab_op[2]  = 4'h2; tab_exp[2]  = 7'b11_1_1_0_1_1;
        tab_op[3]  = 4'h4; tab_exp[3]  = 7'b11_1_0_1_1_1;
        tab_op[4]  = 4'h6; tab_exp[4]  = 7'b10_1_0_0_1_1;
        tab_op[5]  = 4'hA; tab_exp[5]  = 7'b00_1_1_0_0_1;
        tab_op[6]  = 4'hB; tab_exp[6]  = 7'b01_1_1_0_1_1;
        tab_op[7]  = 4'hD; tab_exp[7]  = 7'b00_0_1_0_1_1;
        tab_op[8]  = 4'hE; tab_exp[8]  = 7'b00_1_1_0_1_1;
        tab_op[9]  = 4'hF; tab_exp[9]  = 7'b00_1_1_0_1_1;
        tab_op[10] = 4'h5; tab_exp[10] = 7'b11_1_0_1_1_1;
        tab_op[11] = 4'h7; tab_exp[11] = 7'b10_1_0_0_1_1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        cond_in   = 8'h00;
        ext_ready = 1'b0;
        uword     = mk(4'h2, 3'd0, 1'b0, 4'hF, 12'hABC);
        repeat (3) step();

        // Reset state with a non-zero microword presented
        chk("rst_ctl", ctlv(), {25'd0, 7'b00_1_1_0_1_0});
        chk("rst_din", {20'd0, din}, 32'h0);
        chk("rst_rin", {20'd0, rin}, 32'h0);
        chk("rst_ctl_out", {28'd0, ctl_out}, 32'h0);
        chk("rst_flags", {30'd0, stk_ovf, stk_unf}, 32'h0);

        // Y sequence 0, 1, 0x040 with ctl_out one cycle behind
        uword = mk(4'h1, 3'd0, 1'b0, 4'h3, 12'h000);
        #1;
        reset_n = 1'b1;
        #1;
        chk("seq_y0", {20'd0, tb_y}, 32'h000);
        step();
        uword = mk(4'h2, 3'd0, 1'b0, 4'h5, 12'h040);
        #1;
        chk("seq_y1", {20'd0, tb_y}, 32'h001);
        chk("seq_ctl1", {28'd0, ctl_out}, 32'h3);
        step();
        chk("seq_y2", {20'd0, tb_y}, 32'h040);
        chk("seq_ctl2", {28'd0, ctl_out}, 32'h5);

        // CJMP on cond_in[3], both polarities
        uword   = mk(4'h3, 3'd3, 1'b0, 4'h0, 12'h2AB);
        cond_in = 8'h08;
        step();
        chk("cjmp_p0_t_s", {30'd0, s1, s0}, 32'h3);
        chk("cjmp_p0_t_din", {20'd0, din}, 32'h2AB);
        cond_in = 8'hF7;
        #1;
        chk("cjmp_p0_f", ctlv(), {25'd0, 7'b00_1_1_0_1_1});
        uword = mk(4'h3, 3'd3, 1'b1, 4'h0, 12'h2AB);
        step();
        chk("cjmp_p1_t_s", {30'd0, s1, s0}, 32'h3);
        cond_in = 8'h08;
        #1;
        chk("cjmp_p1_f", ctlv(), {25'd0, 7'b00_1_1_0_1_1});

        // LDCT 3 then RPCT to self: three branches, then falls through
        uword = mk(4'h8, 3'd0, 1'b0, 4'h0, 12'h003);
        step();
        chk("ldct_s", {30'd0, s1, s0}, 32'h0);
        uword = mk(4'h9, 3'd0, 1'b0, 4'h0, 12'h010);
        step();
        chk("rpct1_s", {30'd0, s1, s0}, 32'h3);
        chk("rpct1_din", {20'd0, din}, 32'h010);
        step();
        chk("rpct2_s", {30'd0, s1, s0}, 32'h3);
        step();
        chk("rpct3_s", {30'd0, s1, s0}, 32'h3);
        step();
        chk("rpct4_s", ctlv(), {25'd0, 7'b00_1_1_0_1_1});
        step();
        chk("rpct5_hold", {30'd0, s1, s0}, 32'h0);

        // Five JSR (failing CJSR between 4th and 5th), then six RTS
        uword = mk(4'h4, 3'd0, 1'b0, 4'h0, 12'h100);
        repeat (4) step();
        chk("jsr_ctl", ctlv(), {25'd0, 7'b11_1_0_1_1_1});
        cond_in = 8'h00;
        uword   = mk(4'h5, 3'd0, 1'b0, 4'h0, 12'h200);
        step();
        chk("cjsr_f_ctl", ctlv(), {25'd0, 7'b00_1_1_0_1_1});
        chk("ovf_after4", {31'd0, stk_ovf}, 32'h0);
        uword = mk(4'h4, 3'd0, 1'b0, 4'h0, 12'h100);
        step();
        chk("ovf_cjsr_f", {31'd0, stk_ovf}, 32'h0);
        uword = mk(4'h6, 3'd0, 1'b0, 4'h0, 12'h000);
        step();
        chk("ovf_after5", {31'd0, stk_ovf}, 32'h1);
        chk("rts_ctl", ctlv(), {25'd0, 7'b10_1_0_0_1_1});
        repeat (4) step();
        chk("unf_after4", {31'd0, stk_unf}, 32'h0);
        step();
        uword = mk(4'h1, 3'd0, 1'b0, 4'h0, 12'h000);
        step();
        chk("unf_after6", {31'd0, stk_unf}, 32'h1);
        step();
        chk("flags_sticky", {30'd0, stk_ovf, stk_unf}, 32'h3);

        // Op decode table (conditional entries with passing test)
        cond_in = 8'h01;
        for (int i = 0; i < 12; i++) begin
            uword = mk(tab_op[i], 3'd0, 1'b0, 4'h0, 12'h555);
            step();
            chk($sformatf("op%0h_ctl", tab_op[i]), ctlv(), {25'd0, tab_exp[i]});
        end

        // WAIT, then reset pulsed mid-wait with a loaded counter
        uword = mk(4'h8, 3'd0, 1'b0, 4'h0, 12'h005);
        step();
        uword     = mk(4'hC, 3'd0, 1'b0, 4'h0, 12'h000);
        ext_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("wait%0d_cin", i), ctlv(), {25'd0, 7'b00_0_1_0_1_1});
        end
        ext_ready = 1'b1;
        #1;
        chk("wait_ready_cin", {31'd0, cin}, 32'h1);
        ext_ready = 1'b0;
        step();
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_zero_n", ctlv(), {25'd0, 7'b00_1_1_0_1_0});
        chk("rst_mid_flags", {30'd0, stk_ovf, stk_unf}, 32'h0);
        uword = mk(4'h9, 3'd0, 1'b0, 4'h0, 12'h123);
        step();
        reset_n = 1'b1;
        step();
        chk("rst_cnt_cleared", {30'd0, s1, s0}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
